// File: rtl/usb_ep_loopback.sv
// usb_ep_loopback: bulk OUT->IN loopback through a single DEPTH-byte packet buffer.
// Latency: OUT commit to txval_o/txdat_o two cycles; txpop_i to next txdat_o one cycle.
// Backpressure: rxrdy_o drops while a packet is held; txcork_o NAKs IN until one is ready.
module usb_ep_loopback #(
  parameter logic [3:0]  OUT_EP = 4'd2,
  parameter logic [3:0]  IN_EP  = 4'd2,
  parameter int unsigned DEPTH  = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        usbrst_i,
  input  logic [3:0]  endpt_i,
  input  logic        rxact_i,
  input  logic        rxval_i,
  input  logic [7:0]  rxdat_i,
  input  logic        rxpktval_i,
  output logic        rxrdy_o,
  input  logic        txact_i,
  input  logic        txpop_i,
  input  logic        txpktfin_i,
  output logic [7:0]  txdat_o,
  output logic        txval_o,
  output logic [11:0] txdat_len_o,
  output logic        txcork_o,
  output logic [15:0] loop_cnt_o,
  output logic [7:0]  drop_cnt_o
);

  // Address width for the RAM, count width one wider so a full buffer (DEPTH) fits.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_TX   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wr_cnt, wr_cnt_nxt;
  logic          ovf, ovf_nxt;
  logic [CW-1:0] pkt_len, pkt_len_nxt;
  logic [CW-1:0] rd_ptr, rd_ptr_nxt;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          byte_fits;
  logic          loop_inc;
  logic          drop_inc;
  logic          hold_nxt;

  logic [7:0]    mem [DEPTH];

  assign byte_fits = (wr_cnt < DEPTH_C);
  assign wr_addr   = wr_cnt[AW-1:0];
  // The RAM is always addressed with the pointer value for the coming cycle, so the
  // registered read data tracks buf[rd_ptr] (read-ahead on every pop).
  assign rd_addr   = rd_ptr_nxt[AW-1:0];

  // Packet-holding outputs release one cycle after entering HOLD from RX, giving the
  // RAM one cycle to present buf[0] before the controller sees txval_o.
  assign hold_nxt  = ((state_nxt == ST_HOLD) || (state_nxt == ST_TX)) && (state != ST_RX);

  // Next-state, pointer and buffer-write decode.
  always_comb begin
    state_nxt   = state;
    wr_cnt_nxt  = wr_cnt;
    ovf_nxt     = ovf;
    pkt_len_nxt = pkt_len;
    rd_ptr_nxt  = rd_ptr;
    wr_en       = 1'b0;
    loop_inc    = 1'b0;
    drop_inc    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rxact_i && (endpt_i == OUT_EP)) begin
          state_nxt  = ST_RX;
          wr_cnt_nxt = '0;
          ovf_nxt    = 1'b0;
        end
      end

      ST_RX: begin
        // A byte arriving with the end-of-packet pulse still lands before commit.
        if (rxval_i) begin
          if (byte_fits) begin
            wr_en      = 1'b1;
            wr_cnt_nxt = wr_cnt + ONE_C;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
        if (rxpktval_i) begin
          if (ovf_nxt) begin
            drop_inc  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            pkt_len_nxt = wr_cnt_nxt;
            rd_ptr_nxt  = '0;
            state_nxt   = ST_HOLD;
          end
        end else if (!rxact_i) begin
          // Data phase ended without a good CRC: discard what was collected.
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      ST_HOLD: begin
        rd_ptr_nxt = '0;
        if (txact_i && (endpt_i == IN_EP)) begin
          state_nxt = ST_TX;
        end
      end

      ST_TX: begin
        // Pops past the end of the packet leave the pointer parked at pkt_len.
        if (txpop_i && (rd_ptr < pkt_len)) begin
          rd_ptr_nxt = rd_ptr + ONE_C;
        end
        if (txpktfin_i) begin
          loop_inc   = 1'b1;
          rd_ptr_nxt = '0;
          state_nxt  = ST_IDLE;
        end else if (!txact_i) begin
          // Host did not ACK: rewind and offer the same packet again.
          rd_ptr_nxt = '0;
          state_nxt  = ST_HOLD;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Bus reset flushes the endpoint but leaves the statistics alone.
    if (usbrst_i) begin
      state_nxt   = ST_IDLE;
      wr_cnt_nxt  = '0;
      ovf_nxt     = 1'b0;
      pkt_len_nxt = '0;
      rd_ptr_nxt  = '0;
      wr_en       = 1'b0;
      loop_inc    = 1'b0;
      drop_inc    = 1'b0;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      wr_cnt  <= '0;
      ovf     <= 1'b0;
      pkt_len <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      wr_cnt  <= wr_cnt_nxt;
      ovf     <= ovf_nxt;
      pkt_len <= pkt_len_nxt;
      rd_ptr  <= rd_ptr_nxt;
    end
  end

  // Packet buffer write port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= rxdat_i;
    end
  end

  // Packet buffer synchronous read port, driving txdat_o directly.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      txdat_o <= 8'h00;
    end else begin
      txdat_o <= mem[rd_addr];
    end
  end

  // Handshake outputs, registered from the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rxrdy_o     <= 1'b1;
      txval_o     <= 1'b0;
      txcork_o    <= 1'b1;
      txdat_len_o <= 12'd0;
    end else begin
      rxrdy_o     <= (state_nxt == ST_IDLE) || (state_nxt == ST_RX);
      txval_o     <= hold_nxt;
      txcork_o    <= !hold_nxt;
      txdat_len_o <= 12'(pkt_len);
    end
  end

  // Statistics: completed loopbacks wrap, discarded packets saturate.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      loop_cnt_o <= 16'd0;
      drop_cnt_o <= 8'd0;
    end else begin
      if (loop_inc) begin
        loop_cnt_o <= loop_cnt_o + 16'd1;
      end
      if (drop_inc && (drop_cnt_o != 8'hFF)) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: doc/usb_ep_loopback.md
# usb_ep_loopback

Bulk endpoint loopback engine on the application side of the USB device controller's endpoint interface, clocked with the controller at 60 MHz. It receives OUT packets addressed to one endpoint into a single packet buffer and returns the same bytes on the next IN transaction to the paired endpoint. It NAKs (corks) IN while no packet is held and refuses OUT while one is held. It is the receive-then-transmit partner of the controller's rx/tx data ports.

## Interface
- OUT_EP, 4'd2, endpoint number accepted for OUT data
- IN_EP, 4'd2, endpoint number served for IN data
- DEPTH, 512, buffer bytes; power of two, 64..2048
- clk_i  in  1  controller clock (60 MHz)
- reset_i  in  1  reset; asynchronous, active-high
- usbrst_i  in  1  USB bus reset from controller; synchronous flush
- endpt_i  in  4  endpoint of current transaction
- rxact_i  in  1  OUT data phase active
- rxval_i  in  1  rxdat_i valid this cycle
- rxdat_i  in  8  OUT data byte
- rxpktval_i  in  1  one-cycle pulse: OUT packet CRC good, end of packet
- rxrdy_o  out  1  buffer free, accept OUT (controller NAKs when 0)
- txact_i  in  1  IN data phase active
- txpop_i  in  1  controller consumed txdat_o this cycle
- txpktfin_i  in  1  one-cycle pulse: IN packet ACKed by host
- txdat_o  out  8  IN data byte
- txval_o  out  1  IN data available
- txdat_len_o  out  12  IN packet length in bytes
- txcork_o  out  1  1 = NAK IN requests
- loop_cnt_o  out  16  completed loopbacks, wraps
- drop_cnt_o  out  8  discarded OUT packets, saturates at 255

## Operation
- States: IDLE, RX, HOLD, TX.
- IDLE: rxrdy_o=1, txcork_o=1, txval_o=0. rxact_i=1 with endpt_i==OUT_EP -> RX, wr_cnt=0.
- RX: each rxval_i=1 writes rxdat_i to buf[wr_cnt]. wr_cnt increments while < DEPTH. Bytes beyond DEPTH are dropped and set ovf.
  - rxpktval_i=1 with ovf=0: pkt_len=wr_cnt (0 legal, a ZLP) -> HOLD.
  - rxpktval_i=1 with ovf=1, or rxact_i=0 without rxpktval_i: drop_cnt_o++ -> IDLE, buffer discarded.
  - A byte with rxval_i and rxpktval_i in the same cycle is written before commit.
- HOLD: rxrdy_o=0, txcork_o=0, txval_o=1, txdat_len_o=pkt_len, rd_ptr=0, txdat_o=buf[0]. txact_i=1 with endpt_i==IN_EP -> TX.
- TX: on txpop_i, rd_ptr++ and txdat_o shows buf[rd_ptr+1] the next cycle. Read-ahead keeps txdat_o valid before each pop.
  - txpktfin_i=1: loop_cnt_o++ -> IDLE.
  - txact_i=0 without txpktfin_i (host no-ACK): -> HOLD, rd_ptr=0, same packet is resent.
  - Pops beyond pkt_len are ignored (rd_ptr holds).
- Transactions on other endpoints are ignored in every state.
- usbrst_i=1 in any state: -> IDLE next cycle, ovf=0, pointers 0. Counters are kept.
- Buffer: simple dual-port RAM, DEPTH x 8, synchronous read.

## Timing
- Reset values: state IDLE, rxrdy_o=1, txcork_o=1, txval_o=0, txdat_o=0, txdat_len_o=0, loop_cnt_o=0, drop_cnt_o=0.
- All outputs are registered, so state-derived outputs change the cycle after the transition event.
- rxpktval_i at cycle n -> txval_o=1, txcork_o=0, txdat_len_o valid, txdat_o=buf[0] at n+2 (one cycle state, one cycle RAM read-ahead).
  - txval_o and txcork_o must not release before txdat_o is valid.
- txpop_i at n -> next byte on txdat_o at n+1. The controller must not pop on consecutive cycles faster than this; with read-ahead a back-to-back pop every cycle is supported.
- txpktfin_i at n -> rxrdy_o=1, txcork_o=1, txval_o=0 at n+1.
- reset_i asynchronous assert clears everything immediately. Deassert is synchronous to clk_i externally.

## Test plan
- 64-byte OUT on EP2, bytes 0x00..0x3F, rxpktval_i -> txdat_len_o=64 and txval_o=1 two cycles later; IN with 64 pops returns 0x00..0x3F; txpktfin_i -> loop_cnt_o=1, rxrdy_o=1.
- Second OUT while in HOLD -> rxrdy_o stays 0, buffer unchanged; IN before any OUT -> txcork_o=1.
- IN with 10 pops then txact_i drops without txpktfin_i -> HOLD; retry returns byte 0 first and the full packet.
- OUT of DEPTH+1 bytes (513) -> discard, drop_cnt_o=1, IDLE; OUT with rxact_i falling and no rxpktval_i -> drop_cnt_o=2.
- ZLP (rxpktval_i, no rxval_i) -> txdat_len_o=0, txval_o=1; txpktfin_i -> IDLE.
- usbrst_i mid-RX and mid-TX -> IDLE next cycle, counters preserved; reset_i asserted mid-TX -> all outputs at reset values in the same cycle.
